// File: rtl/spi_frame_tx_pkg.sv
// Shared constants, state encoding and helpers for the SPI frame transmitter.
package spi_frame_tx_pkg;

  localparam int FRAME_W   = 81;
  localparam int PAYLOAD_W = 57;
  localparam logic [15:0] FRAME_HDR  = 16'h55AB;
  localparam logic [7:0]  FRAME_TAIL = 8'hAA;

  // Bit counter covers bit indices 0..FRAME_W-1
  localparam int BIT_CNT_W = 7;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = 7'd80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  // Wrap a payload with the header and tail, MSB first
  function automatic logic [FRAME_W-1:0] build_frame(input logic [PAYLOAD_W-1:0] payload);
    return {FRAME_HDR, payload, FRAME_TAIL};
  endfunction

  // Width wide enough to hold the largest timing parameter
  function automatic int counter_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spi_frame_tx_sck_gen.sv
// Half-period counter that produces sck as a plain flop output.
// The rise/fall strobes mark the clk edge at which sck is about to toggle,
// so logic clocked on that same edge moves in step with sck.
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int HALF_W = (CLK_DIV > 1) ? $clog2(CLK_DIV + 1) : 1;
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_DIV - 1);

  logic [HALF_W-1:0] half_cnt;
  logic              toggle;

  assign toggle = en && (half_cnt == HALF_LAST);
  assign rise   = toggle && !sck;
  assign fall   = toggle && sck;

  // Count out each half period; park sck low with the counter cleared when disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt <= '0;
      sck      <= 1'b0;
    end else if (!en) begin
      half_cnt <= '0;
      sck      <= 1'b0;
    end else if (toggle) begin
      half_cnt <= '0;
      sck      <= ~sck;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_frame_tx.sv
// SPI master: frames a 57-bit payload as {header, payload, tail} and shifts it
// out MSB first on sdi, with sdi changing only on sck falling edges.
module spi_frame_tx
  import spi_frame_tx_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int IDLE_GAP = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PAYLOAD_W-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 sck,
  output logic                 cs,
  output logic                 sdi
);

  localparam int CNT_W = counter_width(CLK_DIV, CS_SETUP, CS_HOLD, IDLE_GAP);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IDLE_GAP - 1);
  // done is registered, so it is raised one cycle before the last gap cycle
  localparam logic [CNT_W-1:0] GAP_PRE    = CNT_W'((IDLE_GAP >= 2) ? IDLE_GAP - 2 : 0);

  state_t               state;
  logic [FRAME_W-1:0]   shreg;
  logic [FRAME_W-1:0]   frame_in;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0]     wait_cnt;
  logic                 final_bit;
  logic                 shift_en;
  logic                 sck_rise;
  logic                 sck_fall;

  assign frame_in = build_frame(tx_data);
  assign shift_en = (state == ST_SHIFT);

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (shift_en),
    .sck  (sck),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  // Frame sequencer: accept, chip-select setup, shift, hold, inter-frame gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
      final_bit <= 1'b0;
      cs        <= 1'b1;
      sdi       <= 1'b0;
      tx_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_valid && tx_ready) begin
            shreg     <= frame_in;
            sdi       <= frame_in[FRAME_W-1];
            cs        <= 1'b0;
            tx_ready  <= 1'b0;
            busy      <= 1'b1;
            wait_cnt  <= '0;
            bit_cnt   <= '0;
            final_bit <= 1'b0;
            state     <= ST_SETUP;
          end else begin
            tx_ready <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (wait_cnt == SETUP_LAST) begin
            wait_cnt <= '0;
            state    <= ST_SHIFT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          // Decide at the rising edge whether this high phase is the last one
          if (sck_rise) begin
            final_bit <= (bit_cnt == LAST_BIT);
          end
          if (sck_fall) begin
            if (final_bit) begin
              state <= ST_HOLD;
            end else begin
              shreg   <= shreg << 1;
              sdi     <= shreg[FRAME_W-2];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (wait_cnt == HOLD_LAST) begin
            wait_cnt <= '0;
            cs       <= 1'b1;
            sdi      <= 1'b0;
            done     <= (IDLE_GAP == 1);
            state    <= ST_GAP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (wait_cnt == GAP_LAST) begin
            wait_cnt <= '0;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            done     <= (wait_cnt == GAP_PRE);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_tx.sv
// Bench for spi_frame_tx: two lanes (CLK_DIV=2 and CLK_DIV=1), each with a
// loopback receiver model and a scoreboard fed by the stimulus at accept time.
module tb_spi_frame_tx;

  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int IDLE_GAP = 4;

  typedef struct packed {
    logic [80:0] frame;
    logic        expect_vld;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n;
  logic [1:0]  tx_valid;
  logic [1:0]  tx_ready;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [1:0]  sck;
  logic [1:0]  cs;
  logic [1:0]  sdi;
  logic [56:0] tx_data [2];

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t exp_q [2][$];
  int   rx_rises [2];
  int   acc_cyc [2];
  int   done_cyc [2];
  int   done_n [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int min);
    tests++;
    if (act < min) begin
      fails++;
      $display("FAIL %s: got %0d, required >= %0d", name, act, min);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    localparam int CD = (gi == 0) ? 2 : 1;
    // Cycles spanned by one frame, accept cycle through done cycle inclusive
    localparam int FRAME_CYC = 1 + CS_SETUP + 162 * CD + CS_HOLD + IDLE_GAP;

    spi_frame_tx #(
      .CLK_DIV (CD),
      .CS_SETUP(CS_SETUP),
      .CS_HOLD (CS_HOLD),
      .IDLE_GAP(IDLE_GAP)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n[gi]),
      .tx_data (tx_data[gi]),
      .tx_valid(tx_valid[gi]),
      .tx_ready(tx_ready[gi]),
      .busy    (busy[gi]),
      .done    (done[gi]),
      .sck     (sck[gi]),
      .cs      (cs[gi]),
      .sdi     (sdi[gi])
    );

    // Receiver model and scoreboard monitor, sampling on the falling clk edge
    initial begin : monitor
      logic [80:0] rx;
      logic cs_p, sck_p, sdi_p, done_p, vld;
      int   lo_len, hi_len, gap_len, acc_c;
      bit   shape_ok, sdi_ok, post_acc, post_done;
      exp_t e;
      rx = '0; cs_p = 1'b1; sck_p = 1'b0; sdi_p = 1'b0; done_p = 1'b0;
      lo_len = 0; hi_len = 0; gap_len = 0; acc_c = 0;
      shape_ok = 1'b1; sdi_ok = 1'b1; post_acc = 1'b0; post_done = 1'b0;
      forever begin
        @(negedge clk);
        if (rst_n[gi]) begin
          if (post_acc) begin
            check_eq($sformatf("busy_after_accept[%0d]", gi), 128'({busy[gi], tx_ready[gi]}), 128'(2'b10));
            post_acc = 1'b0;
          end
          if (post_done) begin
            check_eq($sformatf("idle_after_done[%0d]", gi), 128'({busy[gi], tx_ready[gi]}), 128'(2'b01));
            post_done = 1'b0;
          end
          if (tx_valid[gi] && tx_ready[gi]) begin
            acc_c = cyc;
            acc_cyc[gi] = cyc;
            post_acc = 1'b1;
          end
          if (done[gi]) begin
            if (done_p) begin
              check_eq($sformatf("done_width[%0d]", gi), 128'(done[gi]), 128'(1'b0));
            end else begin
              check_eq($sformatf("done_latency[%0d]", gi), 128'(cyc - acc_c + 1), 128'(FRAME_CYC));
              done_cyc[gi] = cyc;
              done_n[gi]++;
              post_done = 1'b1;
            end
          end
        end else begin
          post_acc = 1'b0;
          post_done = 1'b0;
        end

        if (cs[gi] === 1'b0) begin
          if (cs_p) begin
            check_ge($sformatf("cs_gap[%0d]", gi), gap_len, IDLE_GAP);
            rx = '0; rx_rises[gi] = 0; shape_ok = 1'b1; sdi_ok = 1'b1;
            lo_len = 0; hi_len = 0;
          end else if (sdi[gi] !== sdi_p && !(sck_p && !sck[gi])) begin
            sdi_ok = 1'b0;
          end
          if (sck[gi] && !sck_p) begin
            rx = {rx[79:0], sdi[gi]};
            rx_rises[gi]++;
            if (rx_rises[gi] > 1 && lo_len != CD) shape_ok = 1'b0;
            hi_len = 1;
          end else if (sck[gi]) begin
            hi_len++;
          end else if (sck_p) begin
            if (hi_len != CD) shape_ok = 1'b0;
            lo_len = 1;
          end else begin
            lo_len++;
          end
          gap_len = 0;
        end else begin
          if (!cs_p) begin
            check_ge($sformatf("frame_expected[%0d]", gi), exp_q[gi].size(), 1);
            if (exp_q[gi].size() > 0) begin
              e = exp_q[gi].pop_front();
              vld = (rx[80:65] == 16'h55AB) && (rx[7:0] == 8'hAA);
              $display("[TB] lane %0d frame rx=%021h rises=%0d vld=%0b expect_vld=%0b",
                       gi, rx, rx_rises[gi], vld, e.expect_vld);
              if (e.expect_vld) begin
                check_eq($sformatf("sck_rises[%0d]", gi), 128'(rx_rises[gi]), 128'(81));
                check_eq($sformatf("rx_frame[%0d]", gi), 128'(rx), 128'(e.frame));
                check_eq($sformatf("rx_vld[%0d]", gi), 128'(vld), 128'(1'b1));
                check_eq($sformatf("sck_sdi_timing[%0d]", gi), 128'({shape_ok, sdi_ok}), 128'(2'b11));
              end else begin
                check_eq($sformatf("abort_vld[%0d]", gi), 128'(vld), 128'(1'b0));
              end
            end
          end
          rx = '0;
          rx_rises[gi] = 0;
          gap_len++;
        end
        cs_p = cs[gi]; sck_p = sck[gi]; sdi_p = sdi[gi]; done_p = done[gi];
      end
    end
  end

  // Present a payload and queue its expected frame once it is accepted
  task automatic send(input int k, input logic [56:0] p, input bit keep_valid, input bit will_abort);
    exp_t e;
    int   n;
    tx_data[k] = p;
    tx_valid[k] = 1'b1;
    n = 0;
    while (tx_ready[k] !== 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq($sformatf("accept_in_time[%0d]", k), 128'(n < 3000), 128'(1'b1));
    e.frame = {16'h55AB, p, 8'hAA};
    e.expect_vld = !will_abort;
    exp_q[k].push_back(e);
    @(posedge clk); #1;
    if (!keep_valid) tx_valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while ((exp_q[k].size() != 0 || tx_ready[k] !== 1'b1) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq($sformatf("idle_in_time[%0d]", k), 128'(n < 5000), 128'(1'b1));
  endtask

  task automatic wait_rises(input int k, input int target);
    int n;
    n = 0;
    while (rx_rises[k] < target && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq($sformatf("reach_bit_%0d[%0d]", target, k), 128'(n < 3000), 128'(1'b1));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [63:0] r;
    int d0;
    rst_n = 2'b11;
    tx_valid = 2'b00;
    tx_data[0] = '0;
    tx_data[1] = '0;
    for (int k = 0; k < 2; k++) begin
      rx_rises[k] = 0; acc_cyc[k] = 0; done_cyc[k] = 0; done_n[k] = 0;
    end
    #2;
    rst_n = 2'b00;
    #1;
    for (int k = 0; k < 2; k++)
      check_eq($sformatf("reset_outputs[%0d]", k),
               128'({cs[k], sck[k], sdi[k], tx_ready[k], busy[k], done[k]}), 128'(6'b100000));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 2'b11;
    for (int k = 0; k < 2; k++)
      check_eq($sformatf("ready_held_at_release[%0d]", k), 128'(tx_ready[k]), 128'(1'b0));
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++)
      check_eq($sformatf("ready_after_release[%0d]", k), 128'(tx_ready[k]), 128'(1'b1));

    // Single frame, known payload
    send(0, 57'h0_2468_ACE1_3579_BD, 1'b0, 1'b0);
    wait_idle(0);
    check_eq("single_done_count", 128'(done_n[0]), 128'(1));

    // Back-to-back with tx_valid held high
    send(0, {57{1'b1}}, 1'b1, 1'b0);
    d0 = done_n[0];
    send(0, 57'h0, 1'b0, 1'b0);
    check_eq("b2b_done_seen", 128'(done_n[0]), 128'(d0 + 1));
    check_eq("b2b_accept_after_done", 128'(acc_cyc[0]), 128'(done_cyc[0] + 1));
    wait_idle(0);

    // tx_valid pulse while busy must be ignored
    send(0, 57'h155, 1'b0, 1'b0);
    wait_rises(0, 20);
    tx_data[0] = 57'h1;
    tx_valid[0] = 1'b1;
    check_eq("ready_low_while_busy", 128'(tx_ready[0]), 128'(1'b0));
    @(posedge clk); #1;
    check_eq("ready_low_after_pulse", 128'(tx_ready[0]), 128'(1'b0));
    tx_valid[0] = 1'b0;
    wait_idle(0);

    // Reset mid-frame around bit 40
    send(0, 57'h1_2345_6789_ABCD_EF, 1'b0, 1'b1);
    wait_rises(0, 40);
    rst_n[0] = 1'b0;
    #1;
    check_eq("abort_cs_sck_immediate", 128'({cs[0], sck[0], sdi[0]}), 128'(3'b100));
    check_eq("abort_ready_busy", 128'({tx_ready[0], busy[0]}), 128'(2'b00));
    repeat (3) @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    @(posedge clk); #1;
    check_eq("ready_after_abort_release", 128'(tx_ready[0]), 128'(1'b1));
    send(0, 57'h0_2468_ACE1_3579_BD, 1'b0, 1'b0);
    wait_idle(0);

    // Random payloads on the CLK_DIV=2 lane
    for (int i = 0; i < 4; i++) begin
      r = {$urandom, $urandom};
      send(0, r[56:0], 1'b0, 1'b0);
      wait_idle(0);
    end

    // CLK_DIV=1 lane: known payload then random payloads
    send(1, 57'h0_2468_ACE1_3579_BD, 1'b0, 1'b0);
    wait_idle(1);
    for (int i = 0; i < 3; i++) begin
      r = {$urandom, $urandom};
      send(1, r[56:0], 1'b0, 1'b0);
      wait_idle(1);
    end

    repeat (10) @(posedge clk);
    #1;
    check_eq("queue0_drained", 128'(exp_q[0].size()), 128'(0));
    check_eq("queue1_drained", 128'(exp_q[1].size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
